// File: rtl/stage3_fc_sequencer.sv
// rtl/stage3_fc_sequencer.sv - frame sequencer in front of the stage-3 FC1 accumulator datapath
//
// Collects N_POS pooled beats (one maxpool frame), replays them to the FC datapath one per
// cycle together with the weight index, waits for the accumulated result and hands it
// downstream over a valid/ready handshake.
//
// Optional feature macro: STAGE3_FC_DBLBUF_EN (ping/pong frame buffers, filling overlaps
// ISSUE/WAIT/HOLD). Undefined: single frame buffer, no overlap.
//
// Ports:
//   clk, reset_n                    clock (rising edge), asynchronous active-low reset
//   i_in_valid, i_in_pooling        pooled beat in (ch0 in LSBs)
//   o_in_ready                      beat accepted this cycle when high with i_in_valid
//   o_fc_clear                      one-cycle clear of the datapath accumulator
//   o_fc_valid, o_fc_data, o_fc_widx  replayed beat and its weight index
//   i_fc_done, i_fc_acc             datapath result pulse and accumulated value
//   o_ot_valid, i_ot_ready, o_ot_acc  downstream result handshake
//   o_busy                          FSM not idle
//   o_err_timeout, o_err_spur       sticky error flags (cleared by reset only)
module stage3_fc_sequencer #(
    parameter int CH       = 3,
    parameter int DW       = 34,
    parameter int N_POS    = 16,
    parameter int ACC_CO   = 3,
    parameter int ACC_BW   = 48,
    parameter int WAIT_MAX = 64
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           i_in_valid,
    input  logic [CH*DW-1:0]               i_in_pooling,
    output logic                           o_in_ready,
    output logic                           o_fc_clear,
    output logic                           o_fc_valid,
    output logic [CH*DW-1:0]               o_fc_data,
    output logic [$clog2(N_POS)-1:0]       o_fc_widx,
    input  logic                           i_fc_done,
    input  logic [ACC_CO*ACC_BW-1:0]       i_fc_acc,
    output logic                           o_ot_valid,
    input  logic                           i_ot_ready,
    output logic [ACC_CO*ACC_BW-1:0]       o_ot_acc,
    output logic                           o_busy,
    output logic                           o_err_timeout,
    output logic                           o_err_spur
);

    localparam int IW = $clog2(N_POS);
    localparam int BW = CH * DW;
    localparam int TW = $clog2(WAIT_MAX + 1);
`ifdef STAGE3_FC_DBLBUF_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif
    localparam int MW = $clog2(NBUF * N_POS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_CLR   = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    state_t         state, state_d, after_frame;
    logic [IW-1:0]  fill_cnt, fill_cnt_d;
    logic [IW-1:0]  issue_cnt, issue_cnt_d;
    logic [TW-1:0]  tmo_cnt, tmo_cnt_d;
    logic [BW-1:0]  buf_mem [NBUF*N_POS];
    logic [MW-1:0]  wr_addr, rd_addr;

    logic           accept;
    logic           frame_in;
    logic           timeout_hit;
    logic           acc_load;

    logic           in_ready_d;
    logic           fc_valid_d;
    logic [BW-1:0]  fc_data_d;
    logic [IW-1:0]  fc_widx_d;

    assign accept      = i_in_valid & o_in_ready;
    assign frame_in    = accept && (fill_cnt == IW'(N_POS - 1));
    // done has priority over the timeout in the final WAIT cycle
    assign timeout_hit = (state == S_WAIT) && !i_fc_done && (tmo_cnt == TW'(WAIT_MAX - 1));

`ifdef STAGE3_FC_DBLBUF_EN
    // wr_sel: buffer being filled; rd_sel: buffer being issued / awaiting its result
    logic       wr_sel, wr_sel_d;
    logic       rd_sel, rd_sel_d;
    logic [1:0] full, full_d;
    logic       frame_release;

    assign frame_release = ((state == S_HOLD) && i_ot_ready) || timeout_hit;
    assign wr_addr       = {wr_sel, fill_cnt};
    assign rd_addr       = {rd_sel, issue_cnt_d};

    // While a frame is in flight the filler can only be writing the other buffer, so a
    // frame completing in the release cycle is the one that becomes pending.
    always_comb begin
        after_frame = S_IDLE;
        if (full[~rd_sel] || frame_in) begin
            after_frame = S_CLR;
        end else if (fill_cnt_d != '0) begin
            after_frame = S_FILL;
        end
    end

    always_comb begin
        full_d   = full;
        wr_sel_d = wr_sel;
        rd_sel_d = rd_sel;
        if (frame_in) begin
            full_d[wr_sel] = 1'b1;
            wr_sel_d       = ~wr_sel;
        end
        if (frame_release) begin
            full_d[rd_sel] = 1'b0;
            rd_sel_d       = ~rd_sel;
        end
        in_ready_d = ~full_d[wr_sel_d];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            full   <= 2'b00;
        end else begin
            wr_sel <= wr_sel_d;
            rd_sel <= rd_sel_d;
            full   <= full_d;
        end
    end
`else
    assign wr_addr     = fill_cnt;
    assign rd_addr     = issue_cnt_d;
    assign after_frame = S_IDLE;
    assign in_ready_d  = (state_d == S_IDLE) || (state_d == S_FILL);
`endif

    // Next-state and counter logic
    always_comb begin
        state_d     = state;
        fill_cnt_d  = fill_cnt;
        issue_cnt_d = issue_cnt;
        tmo_cnt_d   = tmo_cnt;
        acc_load    = 1'b0;

        if (accept) begin
            fill_cnt_d = frame_in ? '0 : fill_cnt + 1'b1;
        end

        case (state)
            S_IDLE, S_FILL: begin
                if (frame_in) begin
                    state_d = S_CLR;
                end else if (accept) begin
                    state_d = S_FILL;
                end
            end
            S_CLR: begin
                state_d     = S_ISSUE;
                issue_cnt_d = '0;
            end
            S_ISSUE: begin
                if (issue_cnt == IW'(N_POS - 1)) begin
                    state_d     = S_WAIT;
                    issue_cnt_d = '0;
                    tmo_cnt_d   = '0;
                end else begin
                    issue_cnt_d = issue_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (i_fc_done) begin
                    state_d   = S_HOLD;
                    acc_load  = 1'b1;
                    tmo_cnt_d = '0;
                end else if (timeout_hit) begin
                    state_d   = after_frame;
                    tmo_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (i_ot_ready) begin
                    state_d = after_frame;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_comb begin
        fc_valid_d = (state_d == S_ISSUE);
        fc_data_d  = fc_valid_d ? buf_mem[rd_addr] : '0;
        fc_widx_d  = fc_valid_d ? issue_cnt_d : '0;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_mem[wr_addr] <= i_in_pooling;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            fill_cnt      <= '0;
            issue_cnt     <= '0;
            tmo_cnt       <= '0;
            o_in_ready    <= 1'b0;
            o_fc_clear    <= 1'b0;
            o_fc_valid    <= 1'b0;
            o_fc_data     <= '0;
            o_fc_widx     <= '0;
            o_ot_valid    <= 1'b0;
            o_ot_acc      <= '0;
            o_busy        <= 1'b0;
            o_err_timeout <= 1'b0;
            o_err_spur    <= 1'b0;
        end else begin
            state      <= state_d;
            fill_cnt   <= fill_cnt_d;
            issue_cnt  <= issue_cnt_d;
            tmo_cnt    <= tmo_cnt_d;
            o_in_ready <= in_ready_d;
            o_fc_clear <= (state_d == S_CLR);
            o_fc_valid <= fc_valid_d;
            o_fc_data  <= fc_data_d;
            o_fc_widx  <= fc_widx_d;
            o_ot_valid <= (state_d == S_HOLD);
            o_busy     <= (state_d != S_IDLE);
            if (acc_load) begin
                o_ot_acc <= i_fc_acc;
            end
            if (timeout_hit) begin
                o_err_timeout <= 1'b1;
            end
            if (i_fc_done && (state != S_WAIT)) begin
                o_err_spur <= 1'b1;
            end
        end
    end

endmodule
